spi_block_slave: RTL and testbench

Slave-side endpoint of the SPI link. It sits directly downstream of the SPI master, on the other end of MOSI/MISO/CS. It assembles 128 MOSI bits into one AES input block and hands the block to the cipher core over a valid/ready handshake. In the same frames it returns the core's previous result block on MISO, MSB first.

---
 rtl/spi_block_slave.sv | 112 +++++++++++
 tb/tb_spi_block_slave.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/spi_block_slave.sv
// rtl/spi_block_slave.sv - SPI slave endpoint assembling 128-bit AES blocks and returning results
// Receives MOSI frames into in_block (valid/ready) and shifts the loaded result block out on MISO.
module spi_block_slave #(
   parameter int BLOCK_W = 128
) (
   input  logic               sclk,
   input  logic               reset,
   input  logic               CS,
   input  logic               MOSI,
   output logic               MISO,
   output logic [BLOCK_W-1:0] in_block,
   output logic               in_valid,
   input  logic               in_ready,
   input  logic [BLOCK_W-1:0] out_block,
   input  logic               out_valid,
   output logic               out_ready,
   output logic               overrun
);

   localparam int CNT_W = $clog2(BLOCK_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BLOCK_W - 1);

   typedef enum logic {RECV, HOLD} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [BLOCK_W-1:0] shift_q, shift_d;
   logic [BLOCK_W-1:0] in_block_q, in_block_d;
   logic               in_valid_q, in_valid_d;
   logic [BLOCK_W-1:0] tx_buf_q, tx_buf_d;
   logic               tx_loaded_q, tx_loaded_d;
   logic               overrun_q, overrun_d;

   assign in_block  = in_block_q;
   assign in_valid  = in_valid_q;
   assign overrun   = overrun_q;
   assign out_ready = !tx_loaded_q && (bit_cnt_q == '0);
   // With a power-of-two block width, ~bit_cnt equals BLOCK_W-1-bit_cnt (MSB first).
   assign MISO      = (!CS && tx_loaded_q) ? tx_buf_q[~bit_cnt_q] : 1'b0;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      in_block_d  = in_block_q;
      in_valid_d  = in_valid_q;
      tx_buf_d    = tx_buf_q;
      tx_loaded_d = tx_loaded_q;
      overrun_d   = overrun_q;

      case (state_q)
         RECV: begin
            if (!CS) begin
               shift_d = {shift_q[BLOCK_W-2:0], MOSI};
               if (bit_cnt_q == LAST_BIT) begin
                  in_block_d  = {shift_q[BLOCK_W-2:0], MOSI};
                  in_valid_d  = 1'b1;
                  bit_cnt_d   = '0;
                  state_d     = HOLD;
                  tx_loaded_d = 1'b0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else begin
               bit_cnt_d = '0;
            end
         end
         HOLD: begin
            if (in_ready) begin
               in_valid_d = 1'b0;
               state_d    = RECV;
               // Zero-gap streaming: this edge's bit opens the next frame.
               if (!CS) begin
                  shift_d   = {shift_q[BLOCK_W-2:0], MOSI};
                  bit_cnt_d = CNT_W'(1);
               end
            end else if (!CS) begin
               overrun_d = 1'b1;
            end
         end
         default: state_d = RECV;
      endcase

      if (out_valid && out_ready) begin
         tx_buf_d    = out_block;
         tx_loaded_d = 1'b1;
      end
   end

   always_ff @(posedge sclk) begin
      if (reset) begin
         state_q     <= RECV;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         in_block_q  <= '0;
         in_valid_q  <= 1'b0;
         tx_buf_q    <= '0;
         tx_loaded_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         in_block_q  <= in_block_d;
         in_valid_q  <= in_valid_d;
         tx_buf_q    <= tx_buf_d;
         tx_loaded_q <= tx_loaded_d;
         overrun_q   <= overrun_d;
      end
   end

endmodule

// File: tb/tb_spi_block_slave.sv
// tb/tb_spi_block_slave.sv - directed self-checking bench for spi_block_slave
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_spi_block_slave;

   logic         sclk;
   logic         reset;
   logic         CS;
   logic         MOSI;
   logic         MISO;
   logic [127:0] in_block;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] out_block;
   logic         out_valid;
   logic         out_ready;
   logic         overrun;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [127:0] RX_A   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] TX_T   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] RX_X   = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] BB_A   = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   localparam logic [127:0] BB_B   = 128'hdeadbeefcafef00d123456789abcdef0;
   localparam logic [127:0] TX_T2  = 128'h8000000000000001c3a5f00ff00f5a3c;
   localparam logic [127:0] ONES   = {128{1'b1}};
   localparam logic [127:0] OV_A   = 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5;
   localparam logic [127:0] OV_B   = 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a;
   localparam logic [127:0] RS_C   = 128'hfedcba98765432100011223344556677;

   spi_block_slave #(.BLOCK_W(128)) dut (
      .sclk      (sclk),
      .reset     (reset),
      .CS        (CS),
      .MOSI      (MOSI),
      .MISO      (MISO),
      .in_block  (in_block),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_block (out_block),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun)
   );

   initial begin
      sclk = 1'b0;
      forever #5 sclk = ~sclk;
   end

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive bits first..first+n-1 of d; optionally check MISO against tx and out_ready low.
   task automatic send_bits(input logic [127:0] d, input int first, input int n,
                            input logic [127:0] tx, input bit chk_miso, input bit chk_ordy);
      for (int i = first; i < first + n; i++) begin
         CS   = 1'b0;
         MOSI = d[127-i];
         #1;
         if (chk_miso) chk("miso_bit", {127'd0, MISO}, {127'd0, tx[127-i]});
         if (chk_ordy) chk("out_ready_in_frame", {127'd0, out_ready}, 128'd0);
         tick();
      end
   endtask

   task automatic load_tx(input logic [127:0] t);
      CS        = 1'b1;
      out_block = t;
      out_valid = 1'b1;
      tick();
      out_valid = 1'b0;
      out_block = '0;
   endtask

   initial begin
      reset     = 1'b1;
      CS        = 1'b1;
      MOSI      = 1'b0;
      in_ready  = 1'b0;
      out_block = '0;
      out_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst_in_valid", {127'd0, in_valid}, 128'd0);
      chk("rst_in_block", in_block, 128'd0);
      chk("rst_out_ready", {127'd0, out_ready}, 128'd1);
      chk("rst_overrun", {127'd0, overrun}, 128'd0);
      CS = 1'b0;
      #1;
      chk("rst_miso", {127'd0, MISO}, 128'd0);
      CS = 1'b1;
      tick();

      // Receive one block
      in_ready = 1'b1;
      send_bits(RX_A, 0, 127, '0, 1'b1, 1'b0);
      chk("rx_valid_before_last", {127'd0, in_valid}, 128'd0);
      send_bits(RX_A, 127, 1, '0, 1'b0, 1'b0);
      CS = 1'b1;
      chk("rx_valid_pulse", {127'd0, in_valid}, 128'd1);
      chk("rx_block", in_block, RX_A);
      chk("rx_overrun", {127'd0, overrun}, 128'd0);
      tick();
      chk("rx_valid_drop", {127'd0, in_valid}, 128'd0);

      // Transmit a loaded block
      chk("tx_ready_idle", {127'd0, out_ready}, 128'd1);
      load_tx(TX_T);
      chk("tx_ready_after_load", {127'd0, out_ready}, 128'd0);
      send_bits(RX_X, 0, 128, TX_T, 1'b1, 1'b1);
      CS = 1'b1;
      #1;
      chk("tx_ready_after_frame", {127'd0, out_ready}, 128'd1);
      chk("tx_rx_block", in_block, RX_X);
      tick();
      chk("tx_valid_drop", {127'd0, in_valid}, 128'd0);

      // Back-to-back frames with CS held low
      send_bits(BB_A, 0, 128, '0, 1'b0, 1'b0);
      chk("bb_valid_a", {127'd0, in_valid}, 128'd1);
      chk("bb_block_a", in_block, BB_A);
      send_bits(BB_B, 0, 1, '0, 1'b0, 1'b0);
      chk("bb_valid_gap", {127'd0, in_valid}, 128'd0);
      send_bits(BB_B, 1, 126, '0, 1'b0, 1'b0);
      chk("bb_valid_pre_b", {127'd0, in_valid}, 128'd0);
      send_bits(BB_B, 127, 1, '0, 1'b0, 1'b0);
      CS = 1'b1;
      chk("bb_valid_b", {127'd0, in_valid}, 128'd1);
      chk("bb_block_b", in_block, BB_B);
      chk("bb_overrun", {127'd0, overrun}, 128'd0);
      tick();

      // Abort after 50 bits; tx block restarts from its MSB
      load_tx(TX_T2);
      send_bits(RX_X, 0, 50, TX_T2, 1'b1, 1'b1);
      CS = 1'b1;
      tick();
      tick();
      chk("abort_ready_kept", {127'd0, out_ready}, 128'd0);
      send_bits(ONES, 0, 128, TX_T2, 1'b1, 1'b1);
      CS = 1'b1;
      chk("abort_block", in_block, ONES);
      chk("abort_valid", {127'd0, in_valid}, 128'd1);
      tick();

      // Overrun: second frame arrives while the first is unaccepted
      in_ready = 1'b0;
      send_bits(OV_A, 0, 128, '0, 1'b1, 1'b0);
      chk("ov_no_overrun_yet", {127'd0, overrun}, 128'd0);
      send_bits(OV_B, 0, 128, '0, 1'b0, 1'b0);
      CS = 1'b1;
      chk("ov_block_held", in_block, OV_A);
      chk("ov_valid_held", {127'd0, in_valid}, 128'd1);
      chk("ov_flag", {127'd0, overrun}, 128'd1);
      in_ready = 1'b1;
      tick();
      chk("ov_handshake", {127'd0, in_valid}, 128'd0);
      chk("ov_sticky", {127'd0, overrun}, 128'd1);

      // Reset mid-frame with tx loaded
      load_tx(TX_T);
      send_bits(RX_X, 0, 70, TX_T, 1'b1, 1'b0);
      reset = 1'b1;
      CS    = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      chk("mrst_in_valid", {127'd0, in_valid}, 128'd0);
      chk("mrst_out_ready", {127'd0, out_ready}, 128'd1);
      chk("mrst_miso", {127'd0, MISO}, 128'd0);
      chk("mrst_overrun", {127'd0, overrun}, 128'd0);
      send_bits(RS_C, 0, 128, '0, 1'b1, 1'b0);
      CS = 1'b1;
      chk("mrst_block", in_block, RS_C);
      chk("mrst_valid", {127'd0, in_valid}, 128'd1);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
